// File: rtl/pingpong_frame_ram_if.sv
// Purpose: writer/reader bundle for the ping-pong frame store (write stream, NRD read ports, bank status).
// Latency: n/a (wiring only); read data arrives one cycle after rd_en, status outputs are combinational or registered in the RAM.
// Backpressure: the writer must honour wr_ready; the reader must wait for rd_avail and hand back banks with rd_release.
interface pingpong_frame_ram_if #(
    parameter int DW  = 8,
    parameter int AW  = 10,
    parameter int NRD = 3
);
    logic              wr;
    logic [DW-1:0]     datain;
    logic              wr_ready;
    logic              frame_done;
    logic              wr_drop;
    logic              rd_avail;
    logic              rd_en;
    logic [NRD*AW-1:0] rd_adr;
    logic [NRD*DW-1:0] dataout;
    logic              rd_valid;
    logic              rd_release;
    logic              wr_bank;
    logic              rd_bank;

    // Producer/consumer side: streams frames in and pulls read data out.
    modport master (
        output wr, datain, rd_en, rd_adr, rd_release,
        input  wr_ready, frame_done, wr_drop, rd_avail, dataout, rd_valid, wr_bank, rd_bank
    );

    // Frame store side.
    modport slave (
        input  wr, datain, rd_en, rd_adr, rd_release,
        output wr_ready, frame_done, wr_drop, rd_avail, dataout, rd_valid, wr_bank, rd_bank
    );
endinterface

// File: rtl/pingpong_frame_ram.sv
// Purpose: two-bank P*P frame store; one bank fills while the other is read by NRD parallel ports.
// Latency: 1 cycle from rd_en to dataout/rd_valid; frame_done one cycle after the last word is accepted.
// Backpressure: wr_ready drops while the write bank is still full; writes attempted then are dropped and flagged sticky.
module pingpong_frame_ram #(
    parameter int DW  = 8,
    parameter int AW  = 10,
    parameter int P   = 28,
    parameter int NRD = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    pingpong_frame_ram_if.slave  bus
);
    localparam int FRAME = P * P;
    localparam int DEPTH = 1 << AW;

    // A frame that cannot fit in one bank would silently wrap the write pointer.
    if (P < 1 || FRAME > DEPTH) begin : g_bad_geometry
        $error("pingpong_frame_ram: P*P must fit in 2**AW words and P must be >= 1");
    end

    localparam logic [AW-1:0] LAST = AW'(FRAME - 1);

    logic [DW-1:0]     mem [2][DEPTH];
    logic [1:0]        full;
    logic [1:0]        full_nxt;
    logic              wr_bank;
    logic              rd_bank;
    logic [AW-1:0]     wcnt;
    logic              frame_done;
    logic              wr_drop;
    logic              rd_valid;
    logic [NRD*DW-1:0] dataout;
    logic [NRD*DW-1:0] rd_data;

    logic wr_ok;
    logic last_word;
    logic rel_ok;
    logic rd_ok;

    assign wr_ok     = bus.wr && !full[wr_bank];
    assign last_word = wr_ok && (wcnt == LAST);
    assign rel_ok    = bus.rd_release && full[rd_bank];
    assign rd_ok     = bus.rd_en && full[rd_bank];

    assign bus.wr_ready   = !full[wr_bank];
    assign bus.rd_avail   = full[rd_bank];
    assign bus.frame_done = frame_done;
    assign bus.wr_drop    = wr_drop;
    assign bus.rd_valid   = rd_valid;
    assign bus.dataout    = dataout;
    assign bus.wr_bank    = wr_bank;
    assign bus.rd_bank    = rd_bank;

    // Completion sets the write bank's bit and release clears the read bank's bit; the two never
    // collide because the writer only fills an empty bank and release only acts on a full one.
    always_comb begin
        full_nxt = full;
        if (last_word) full_nxt[wr_bank] = 1'b1;
        if (rel_ok)    full_nxt[rd_bank] = 1'b0;
    end

    // Per-port read mux; addresses beyond the frame read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NRD; i++) begin
            if (int'(bus.rd_adr[i*AW +: AW]) < FRAME) begin
                rd_data[i*DW +: DW] = mem[rd_bank][bus.rd_adr[i*AW +: AW]];
            end
        end
    end

    // Storage: no reset, stale contents stay hidden behind the full flags.
    always_ff @(posedge clk) begin
        if (wr_ok && !rst) begin
            mem[wr_bank][wcnt] <= bus.datain;
        end
    end

    // Bank bookkeeping: write pointer, bank swaps, full flags and write-side status.
    always_ff @(posedge clk) begin
        if (rst) begin
            full       <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wcnt       <= '0;
            frame_done <= 1'b0;
            wr_drop    <= 1'b0;
        end else begin
            full       <= full_nxt;
            frame_done <= last_word;
            if (bus.wr && full[wr_bank]) begin
                wr_drop <= 1'b1;
            end
            if (wr_ok) begin
                if (last_word) begin
                    wcnt    <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
            end
            // The read in this cycle already used the old rd_bank, so the swap is safe here.
            if (rel_ok) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    // Registered read ports: capture on a valid read, otherwise hold the last data.
    always_ff @(posedge clk) begin
        if (rst) begin
            dataout  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_ok;
            if (rd_ok) begin
                dataout <= rd_data;
            end
        end
    end
endmodule

// File: tb/tb_pingpong_frame_ram.sv
// Purpose: randomized plus directed check of the ping-pong frame store against a frame-queue reference model.
// Latency: model predicts each output right after the clock edge it follows.
// Backpressure: model treats the store as a two-deep queue of completed frames.
module tb_pingpong_frame_ram;
    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int P   = 3;
    localparam int NRD = 3;
    localparam int FR  = P * P;
    localparam int AWN = NRD * AW;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pingpong_frame_ram_if #(.DW(DW), .AW(AW), .NRD(NRD)) bus ();

    pingpong_frame_ram #(.DW(DW), .AW(AW), .P(P), .NRD(NRD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: completed frames queue in arrival order; banks alternate with the frame counts.
    logic [FR*DW-1:0]  frames[$];
    logic [DW-1:0]     part[$];
    int                nw      = 0;
    int                nr      = 0;
    logic              m_fd    = 1'b0;
    logic              m_drop  = 1'b0;
    logic              m_valid = 1'b0;
    logic [NRD*DW-1:0] m_dout  = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic w, input logic [DW-1:0] d,
                                input logic re, input logic [AWN-1:0] a, input logic rel);
        bit               avail;
        bit               ready;
        int               ai;
        logic [FR*DW-1:0] cur;
        logic [FR*DW-1:0] f;
        if (r) begin
            frames.delete();
            part.delete();
            nw      = 0;
            nr      = 0;
            m_fd    = 1'b0;
            m_drop  = 1'b0;
            m_valid = 1'b0;
            m_dout  = '0;
        end else begin
            avail   = frames.size() > 0;
            ready   = frames.size() < 2;
            m_valid = re && avail;
            if (re && avail) begin
                cur = frames[0];
                for (int i = 0; i < NRD; i++) begin
                    ai = int'(a[i*AW +: AW]);
                    m_dout[i*DW +: DW] = (ai < FR) ? cur[ai*DW +: DW] : '0;
                end
            end
            m_fd = 1'b0;
            if (w && ready) begin
                part.push_back(d);
                if (part.size() == FR) begin
                    f = '0;
                    for (int k = 0; k < FR; k++) f[k*DW +: DW] = part[k];
                    frames.push_back(f);
                    part.delete();
                    nw++;
                    m_fd = 1'b1;
                end
            end else if (w) begin
                m_drop = 1'b1;
            end
            if (rel && avail) begin
                void'(frames.pop_front());
                nr++;
            end
        end
    endtask

    task automatic check_all();
        check_eq("wr_ready",   64'(bus.wr_ready),   64'(frames.size() < 2));
        check_eq("rd_avail",   64'(bus.rd_avail),   64'(frames.size() > 0));
        check_eq("wr_bank",    64'(bus.wr_bank),    64'(nw % 2));
        check_eq("rd_bank",    64'(bus.rd_bank),    64'(nr % 2));
        check_eq("frame_done", 64'(bus.frame_done), 64'(m_fd));
        check_eq("wr_drop",    64'(bus.wr_drop),    64'(m_drop));
        check_eq("rd_valid",   64'(bus.rd_valid),   64'(m_valid));
        check_eq("dataout",    64'(bus.dataout),    64'(m_dout));
    endtask

    task automatic step(input logic r, input logic w, input logic [DW-1:0] d,
                        input logic re, input logic [AWN-1:0] a, input logic rel);
        rst            = r;
        bus.wr         = w;
        bus.datain     = d;
        bus.rd_en      = re;
        bus.rd_adr     = a;
        bus.rd_release = rel;
        @(posedge clk);
        model_update(r, w, d, re, a, rel);
        #1;
        check_all();
    endtask

    task automatic wr_word(input logic [DW-1:0] d);
        step(1'b0, 1'b1, d, 1'b0, '0, 1'b0);
    endtask

    initial begin : main
        logic [AWN-1:0] a;
        logic [DW-1:0]  d;
        logic           r, w, re, rel;

        rst            = 1'b1;
        bus.wr         = 1'b0;
        bus.datain     = '0;
        bus.rd_en      = 1'b0;
        bus.rd_adr     = '0;
        bus.rd_release = 1'b0;

        // Reset state.
        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        check_eq("rst_dataout", 64'(bus.dataout), 64'd0);

        // First frame 1..9 into bank 0.
        for (int v = 1; v <= FR; v++) wr_word(DW'(v));
        check_eq("fd_after_9", 64'(bus.frame_done), 64'd1);
        check_eq("wbank_swap", 64'(bus.wr_bank), 64'd1);
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        check_eq("fd_one_cycle", 64'(bus.frame_done), 64'd0);

        // Reads across the frame and one past its end.
        step(1'b0, 1'b0, '0, 1'b1, {4'd8, 4'd4, 4'd0}, 1'b0);
        check_eq("rd_048", 64'(bus.dataout), 64'h09_05_01);
        step(1'b0, 1'b0, '0, 1'b1, {4'd0, 4'd9, 4'd2}, 1'b0);
        check_eq("rd_oob", 64'(bus.dataout), 64'h01_00_03);
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);

        // Fill bank 1 with 11..19 while bank 0 is being read.
        for (int v = 1; v <= FR; v++) begin
            a = AWN'($urandom);
            step(1'b0, 1'b1, DW'(10 + v), 1'b1, a, 1'b0);
        end
        wr_word(8'd20);
        check_eq("drop_set", 64'(bus.wr_drop), 64'd1);
        check_eq("full_stall", 64'(bus.wr_ready), 64'd0);

        // Release bank 0, then read bank 1.
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        check_eq("rel_rbank", 64'(bus.rd_bank), 64'd1);
        check_eq("rel_ready", 64'(bus.wr_ready), 64'd1);
        step(1'b0, 1'b0, '0, 1'b1, {4'd8, 4'd4, 4'd0}, 1'b0);
        check_eq("rd_bank1", 64'(bus.dataout), 64'h13_0F_0B);

        // Read and release together, then a release with nothing available.
        step(1'b0, 1'b0, '0, 1'b1, {4'd1, 4'd2, 4'd3}, 1'b1);
        check_eq("rd_rel_data", 64'(bus.dataout), 64'h0C_0D_0E);
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, {4'd1, 4'd2, 4'd3}, 1'b0);
        check_eq("rd_noavail_hold", 64'(bus.rd_valid), 64'd0);

        // Reset after a partial frame; a fresh frame lands at bank 0 from address 0.
        for (int v = 1; v <= 5; v++) wr_word(DW'(50 + v));
        step(1'b1, 1'b1, 8'hAA, 1'b1, '0, 1'b1);
        for (int v = 1; v <= FR; v++) wr_word(DW'(30 + v));
        step(1'b0, 1'b0, '0, 1'b1, {4'd8, 4'd4, 4'd0}, 1'b0);
        check_eq("post_rst_frame", 64'(bus.dataout), 64'h27_23_1F);

        // Completing bank 1 on the same edge that releases bank 0.
        for (int v = 1; v < FR; v++) wr_word(DW'(60 + v));
        step(1'b0, 1'b1, 8'd69, 1'b0, '0, 1'b1);
        check_eq("sim_fd", 64'(bus.frame_done), 64'd1);
        check_eq("sim_wbank", 64'(bus.wr_bank), 64'd0);
        check_eq("sim_rbank", 64'(bus.rd_bank), 64'd1);

        // Random traffic with occasional reset.
        for (int n = 0; n < 3000; n++) begin
            r   = ($urandom_range(0, 199) == 0);
            w   = ($urandom_range(0, 3) != 0);
            re  = ($urandom_range(0, 1) == 1);
            rel = ($urandom_range(0, 9) == 0);
            d   = DW'($urandom);
            a   = AWN'($urandom);
            step(r, w, d, re, a, rel);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
